// File: rtl/sc_stream_to_binary.sv
// Stochastic-stream to binary converter: counts ones over back-to-back windows of 2^WINDOW_LOG2 qualified bits.
// Optional signed output out_bipolar (2*count - N) is enabled by defining SC_STREAM_BIPOLAR_EN.
module sc_stream_to_binary #(
  parameter int unsigned WINDOW_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic [WINDOW_LOG2:0]   out_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
`ifdef SC_STREAM_BIPOLAR_EN
  output logic [WINDOW_LOG2+1:0] out_bipolar,
`endif
  output logic                   busy
);

  localparam logic [WINDOW_LOG2-1:0] SAMP_ONE = (WINDOW_LOG2)'(1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                 state, state_nxt;
  logic [WINDOW_LOG2-1:0] samp_cnt, samp_nxt;
  logic [WINDOW_LOG2:0]   ones_cnt, ones_nxt, ones_inc;
  logic                   load;

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    ones_nxt  = ones_cnt;
    load      = 1'b0;
    ones_inc  = ones_cnt + {{WINDOW_LOG2{1'b0}}, in_bit};
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = ACCUM;
          samp_nxt  = '0;
          ones_nxt  = '0;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_nxt = IDLE;
          samp_nxt  = '0;
          ones_nxt  = '0;
        end else if (in_valid) begin
          // Last bit of the window: publish count including this bit, restart without a gap.
          if (samp_cnt == '1) begin
            load     = 1'b1;
            samp_nxt = '0;
            ones_nxt = '0;
          end else begin
            samp_nxt = samp_cnt + SAMP_ONE;
            ones_nxt = ones_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      samp_cnt <= '0;
      ones_cnt <= '0;
    end else begin
      state    <= state_nxt;
      samp_cnt <= samp_nxt;
      ones_cnt <= ones_nxt;
    end
  end

  assign busy = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_value <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      out_value <= ones_inc;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SC_STREAM_BIPOLAR_EN
  localparam logic [WINDOW_LOG2+1:0] N_BI  = (WINDOW_LOG2+2)'(1 << WINDOW_LOG2);
  localparam logic [WINDOW_LOG2+1:0] NEG_N = (WINDOW_LOG2+2)'(-(1 << WINDOW_LOG2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_bipolar <= NEG_N;
    end else if (load) begin
      out_bipolar <= {ones_inc, 1'b0} - N_BI;
    end
  end
`endif

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Randomized + directed bench for sc_stream_to_binary (WINDOW_LOG2=4) with queue scoreboard
// and a window-of-bits reference model.
module tb_sc_stream_to_binary;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, in_bit, out_ready;
  logic [4:0] out_value;
  logic       out_valid, overrun, busy;
`ifdef SC_STREAM_BIPOLAR_EN
  logic [5:0] out_bipolar;
`endif

  sc_stream_to_binary #(.WINDOW_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
`ifdef SC_STREAM_BIPOLAR_EN
    .out_bipolar (out_bipolar),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // Reference model state: bits gathered in the open window and pending results.
  int win[$];
  int sb[$];
  bit m_busy = 0;
  int exp_value = 0;
  bit exp_valid = 0;
  bit exp_overrun = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hs, load;
    int s;
    if (!rst) begin
      win.delete(); sb.delete();
      m_busy = 0; exp_valid = 0; exp_overrun = 0; exp_value = 0;
      return;
    end
    hs = exp_valid && out_ready;
    load = 0;
    s = 0;
    if (!m_busy) begin
      if (en) begin m_busy = 1; win.delete(); end
    end else if (!en) begin
      m_busy = 0; win.delete();
    end else if (in_valid) begin
      win.push_back(int'(in_bit));
      if (win.size() == N) begin
        foreach (win[k]) s += win[k];
        load = 1;
        win.delete();
      end
    end
    if (load) begin
      if (exp_valid && !out_ready) begin
        exp_overrun = 1;
        void'(sb.pop_back());
      end
      sb.push_back(s);
      exp_value = s;
      exp_valid = 1;
    end else if (hs) begin
      exp_valid = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit v, input bit b, input bit rd);
    rst = r; en = e; in_valid = v; in_bit = b; out_ready = rd;
    @(posedge clk);
    #2;
    model_step();
    started = 1;
  endtask

  // Monitor: status every cycle, scoreboard pop on each accepted result.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (started) begin
        check("out_valid", out_valid, exp_valid);
        check("overrun", overrun, exp_overrun);
        check("busy", busy, m_busy);
        check("out_value", out_value, exp_value);
`ifdef SC_STREAM_BIPOLAR_EN
        check("out_bipolar", {{26{out_bipolar[5]}}, out_bipolar}, 2 * exp_value - N);
`endif
        if (rst && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
          end else begin
            e = sb.pop_front();
            check("handshake_value", out_value, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 0; en = 0; in_valid = 0; in_bit = 0; out_ready = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1);
    check("rst_value", out_value, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);

    // 1010... window, consumer ready
    cyc(1, 1, 0, 1, 1);
    for (int i = 0; i < N; i++) cyc(1, 1, 1, (i % 2) == 0, 1);
    check("alt_value", out_value, 8);
    check("alt_valid", out_valid, 1);
    cyc(1, 1, 0, 0, 1);
    check("alt_one_cycle", out_valid, 0);

    // all ones then all zeros, back-to-back
    for (int i = 0; i < N; i++) cyc(1, 1, 1, 1, 1);
    check("ones_value", out_value, 16);
    for (int i = 0; i < N; i++) cyc(1, 1, 1, 0, 1);
    check("zeros_value", out_value, 0);
    check("zeros_valid", out_valid, 1);

    // 50% in_valid duty, in_bit=1
    for (int i = 0; i < 2 * N; i++) begin
      cyc(1, 1, (i % 2) == 1, 1, 1);
      if (i == 2 * N - 2) check("duty_not_yet", out_valid, 0);
    end
    check("duty_value", out_value, 16);
    check("duty_valid", out_valid, 1);

    // two windows unconsumed: 5 ones then 9 ones
    for (int i = 0; i < N; i++) cyc(1, 1, 1, i < 5, 0);
    for (int i = 0; i < N; i++) cyc(1, 1, 1, i < 9, 0);
    check("ovr_value", out_value, 9);
    check("ovr_valid", out_valid, 1);
    check("ovr_flag", overrun, 1);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 1);
    check("ovr_sticky", overrun, 1);
    check("ovr_consumed", out_valid, 0);

    // abort after 7 bits, restart, 4 ones
    cyc(0, 0, 0, 0, 1);
    check("ovr_reset", overrun, 0);
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 1, 1);
    cyc(1, 0, 1, 1, 1);
    check("abort_idle", busy, 0);
    cyc(1, 1, 1, 1, 1);
    for (int i = 0; i < N; i++) cyc(1, 1, 1, i < 4, 1);
    check("abort_value", out_value, 4);

    // reset mid-window while a result is pending
    for (int i = 0; i < N; i++) cyc(1, 1, 1, i < 3, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 1, 0);
    check("pre_rst_valid", out_valid, 1);
    cyc(0, 1, 1, 1, 1);
    check("rst2_value", out_value, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_overrun", overrun, 0);
    check("rst2_busy", busy, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 149) != 0, $urandom_range(0, 59) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
